// File: rtl/fft_frame_driver.sv
// Captures a 64-sample audio frame into an FFT core, waits for the transform,
// then streams the result bins out and reports the peak bin of the lower half.
module fft_frame_driver #(
  parameter int READ_LAT   = 1,
  parameter int WAIT_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        fft_reset,
  output logic        fft_load,
  output logic [5:0]  fft_load_address,
  output logic [31:0] fft_data_in,
  output logic        fft_start,
  input  logic        fft_done,
  input  logic [31:0] fft_data_out,
  output logic        bin_valid,
  output logic [5:0]  bin_index,
  output logic [31:0] bin_data,
  output logic        peak_valid,
  output logic [5:0]  peak_index,
  output logic [16:0] peak_mag,
  output logic        busy,
  output logic        timeout
);
  localparam int DW = $clog2(64 + READ_LAT + 1);
  localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  typedef enum logic [2:0] {IDLE, CLR, LOAD, START, WAIT, DRAIN, REPORT} state_t;

  state_t          state;
  logic [5:0]      load_count;
  logic [DW-1:0]   drain_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [5:0]      best_idx;
  logic [16:0]     best_mag;

  logic [DW-1:0]   d_cur;
  logic            capture;
  logic [5:0]      cap_idx;
  logic [16:0]     cap_mag;
  logic [5:0]      best_idx_nxt;
  logic [16:0]     best_mag_nxt;

  // |v| widened to 17 bits so that -32768 maps to 32768 without saturating
  function automatic logic [16:0] abs16(input logic [15:0] v);
    logic [16:0] e;
    e = {v[15], v};
    return v[15] ? (~e + 17'd1) : e;
  endfunction

  assign sample_ready = (state == LOAD);
  assign busy         = (state != IDLE);

  // The fft_done cycle itself is drain count 0, so it can already capture when READ_LAT=0
  always_comb begin
    d_cur        = (state == WAIT) ? '0 : drain_cnt;
    capture      = ((state == DRAIN) || (state == WAIT && fft_done)) &&
                   (d_cur >= DW'(READ_LAT));
    cap_idx      = 6'(d_cur - DW'(READ_LAT));
    cap_mag      = abs16(fft_data_out[31:16]) + abs16(fft_data_out[15:0]);
    best_idx_nxt = (state == WAIT) ? '0 : best_idx;
    best_mag_nxt = (state == WAIT) ? '0 : best_mag;
    if (capture && cap_idx >= 6'd1 && cap_idx <= 6'd31 && cap_mag > best_mag_nxt) begin
      best_idx_nxt = cap_idx;
      best_mag_nxt = cap_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      load_count       <= '0;
      drain_cnt        <= '0;
      wait_cnt         <= '0;
      best_idx         <= '0;
      best_mag         <= '0;
      fft_reset        <= 1'b0;
      fft_load         <= 1'b0;
      fft_load_address <= '0;
      fft_data_in      <= '0;
      fft_start        <= 1'b0;
      bin_valid        <= 1'b0;
      bin_index        <= '0;
      bin_data         <= '0;
      peak_valid       <= 1'b0;
      peak_index       <= '0;
      peak_mag         <= '0;
      timeout          <= 1'b0;
    end else begin
      fft_reset  <= 1'b0;
      fft_load   <= 1'b0;
      fft_start  <= 1'b0;
      bin_valid  <= 1'b0;
      peak_valid <= 1'b0;
      if (capture) begin
        bin_valid <= 1'b1;
        bin_index <= cap_idx;
        bin_data  <= fft_data_out;
      end
      case (state)
        IDLE: begin
          load_count <= '0;
          if (sample_valid) begin
            state     <= CLR;
            fft_reset <= 1'b1;
          end
        end
        CLR: state <= LOAD;
        LOAD: if (sample_valid) begin
          fft_load         <= 1'b1;
          fft_load_address <= load_count;
          fft_data_in      <= {sample_in, 16'h0000};
          load_count       <= load_count + 6'd1;
          if (load_count == 6'd63) state <= START;
        end
        START: begin
          fft_start <= 1'b1;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (fft_done) begin
            drain_cnt <= DW'(1);
            best_idx  <= best_idx_nxt;
            best_mag  <= best_mag_nxt;
            state     <= DRAIN;
          end else if (wait_cnt == WW'(WAIT_LIMIT - 1)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          best_idx  <= best_idx_nxt;
          best_mag  <= best_mag_nxt;
          if (capture && cap_idx == 6'd63) begin
            peak_valid <= 1'b1;
            peak_index <= best_idx_nxt;
            peak_mag   <= best_mag_nxt;
            state      <= REPORT;
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_driver.sv
// Bench for fft_frame_driver: drives frames, models the FFT core, and checks
// loads, bins and peak reports against a queue-based reference.
module tb_fft_frame_driver;
  localparam int RL = 1;
  localparam int WL = 1023;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, fft_reset, fft_load, fft_start;
  logic [5:0]  fft_load_address;
  logic [31:0] fft_data_in;
  logic        fft_done = 1'b0;
  logic [31:0] fft_data_out = '0;
  logic        bin_valid, peak_valid, busy, timeout;
  logic [5:0]  bin_index, peak_index;
  logic [31:0] bin_data;
  logic [16:0] peak_mag;

  fft_frame_driver #(.READ_LAT(RL), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .fft_reset(fft_reset), .fft_load(fft_load),
    .fft_load_address(fft_load_address), .fft_data_in(fft_data_in),
    .fft_start(fft_start), .fft_done(fft_done), .fft_data_out(fft_data_out),
    .bin_valid(bin_valid), .bin_index(bin_index), .bin_data(bin_data),
    .peak_valid(peak_valid), .peak_index(peak_index), .peak_mag(peak_mag),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [5:0] a; logic [31:0] d; } ev_t;
  ev_t         load_q[$], bin_q[$];
  int          rst_q[$], start_q[$];
  ev_t         mon_e;
  int          npeak = 0, peak_c = 0, viol = 0, to_rise = -1;
  logic [5:0]  pk_idx;
  logic [16:0] pk_mag;
  logic        p_rst = 0, p_start = 0, p_peak = 0, p_to = 0;

  // Observer: event logs plus pulse-width / exclusivity bookkeeping
  always @(negedge clk) begin
    if (fft_load === 1'b1) begin
      mon_e.c = cyc; mon_e.a = fft_load_address; mon_e.d = fft_data_in; load_q.push_back(mon_e);
    end
    if (bin_valid === 1'b1) begin
      mon_e.c = cyc; mon_e.a = bin_index; mon_e.d = bin_data; bin_q.push_back(mon_e);
    end
    if (fft_reset === 1'b1) rst_q.push_back(cyc);
    if (fft_start === 1'b1) start_q.push_back(cyc);
    if (peak_valid === 1'b1) begin
      npeak++; peak_c = cyc; pk_idx = peak_index; pk_mag = peak_mag;
    end
    if (int'(fft_load === 1'b1) + int'(fft_start === 1'b1) + int'(fft_reset === 1'b1) > 1) viol++;
    if ((fft_reset === 1'b1 && p_rst) || (fft_start === 1'b1 && p_start) ||
        (peak_valid === 1'b1 && p_peak)) viol++;
    if (timeout === 1'b1 && !p_to) to_rise = cyc;
    p_rst = (fft_reset === 1'b1); p_start = (fft_start === 1'b1);
    p_peak = (peak_valid === 1'b1); p_to = (timeout === 1'b1);
  end

  int          vectors = 0, errors = 0;
  logic [31:0] bins_m[64];
  logic [15:0] smp_m[64];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Peak of bins 1..31 by |re|+|im|, first strict maximum wins
  function automatic void ref_peak(output int pi, output int pm);
    int m;
    pi = 0; pm = 0;
    for (int k = 1; k < 32; k++) begin
      m = iabs(int'($signed(bins_m[k][31:16]))) + iabs(int'($signed(bins_m[k][15:0])));
      if (m > pm) begin pm = m; pi = k; end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sample_valid = 1'b0; fft_done = 1'b0; fft_data_out = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_samples();
    for (int k = 0; k < 64; k++) smp_m[k] = 16'($urandom);
  endtask

  task automatic rand_bins();
    for (int k = 0; k < 64; k++) begin
      bins_m[k] = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
      if ($urandom_range(0, 7) == 0) bins_m[k][31:16] = 16'h8000;
      if ($urandom_range(0, 7) == 0) bins_m[k][15:0]  = 16'h8000;
    end
  endtask

  // One full frame: load, FFT model (or silence), then check everything the frame produced
  task automatic run_frame(input bit gaps, input bit do_done, input string tag);
    int lb, bb, sb, rb, pn, v0, idx, g, dc, nl, nb, pi, pm, sc;
    bit tog;
    lb = load_q.size(); bb = bin_q.size(); sb = start_q.size(); rb = rst_q.size();
    pn = npeak; v0 = viol; idx = 0; g = 0; tog = 1'b1; dc = 0;
    while (idx < 64 && g < 400) begin
      @(negedge clk);
      sample_valid = gaps ? tog : 1'b1;
      tog = !tog;
      sample_in = smp_m[idx];
      if (sample_valid && sample_ready) idx++;
      g++;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    g = 0;
    while (start_q.size() == sb && g < 10) begin @(negedge clk); g++; end
    repeat (38) begin
      @(negedge clk);
      sample_valid = 1'($urandom); sample_in = 16'($urandom);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    if (do_done) begin
      @(negedge clk);
      fft_done = 1'b1; dc = cyc;
      for (int j = 0; j <= 63 + RL; j++) begin
        if (j > 0) @(negedge clk);
        if (j >= RL) fft_data_out = bins_m[j - RL];
        else fft_data_out = $urandom;
      end
      g = 0;
      while (npeak == pn && g < 10) begin @(negedge clk); g++; end
      fft_done = 1'b0; fft_data_out = '0;
    end else begin
      g = 0;
      while (busy && g < 1100) begin @(negedge clk); g++; end
    end
    repeat (2) @(negedge clk);

    nl = load_q.size() - lb;
    vectors++;
    if (nl !== 64) begin errors++; $display("FAIL %s load_count got %0d want 64", tag, nl); end
    for (int k = 0; k < 64 && k < nl; k++) begin
      vectors++;
      if (load_q[lb+k].a !== 6'(k) || load_q[lb+k].d !== {smp_m[k], 16'h0000}) begin
        errors++;
        $display("FAIL %s load[%0d] got addr %0d data %h want addr %0d data %h", tag, k,
                 load_q[lb+k].a, load_q[lb+k].d, k, {smp_m[k], 16'h0000});
      end
    end
    if (nl == 64) begin
      vectors++;
      if (load_q[lb+63].c - load_q[lb].c !== (gaps ? 126 : 63)) begin
        errors++;
        $display("FAIL %s load_span got %0d want %0d", tag, load_q[lb+63].c - load_q[lb].c, gaps ? 126 : 63);
      end
      vectors++;
      if (rst_q.size() - rb !== 1 || rst_q[rb] !== load_q[lb].c - 2) begin
        errors++;
        $display("FAIL %s clr_pulse got %0d pulses want 1 at cycle %0d", tag, rst_q.size() - rb, load_q[lb].c - 2);
      end
      sc = (start_q.size() > sb) ? start_q[sb] : -1;
      vectors++;
      if (start_q.size() - sb !== 1 || sc !== load_q[lb+63].c + 1) begin
        errors++;
        $display("FAIL %s start_pulse got cycle %0d want %0d", tag, sc, load_q[lb+63].c + 1);
      end
    end
    vectors++;
    if (viol !== v0) begin errors++; $display("FAIL %s pulse_protocol got %0d violations want 0", tag, viol - v0); end

    nb = bin_q.size() - bb;
    if (do_done) begin
      vectors++;
      if (nb !== 64) begin errors++; $display("FAIL %s bin_count got %0d want 64", tag, nb); end
      for (int k = 0; k < 64 && k < nb; k++) begin
        vectors++;
        if (bin_q[bb+k].a !== 6'(k) || bin_q[bb+k].d !== bins_m[k] || bin_q[bb+k].c !== dc + 1 + RL + k) begin
          errors++;
          $display("FAIL %s bin[%0d] got idx %0d data %h cyc %0d want idx %0d data %h cyc %0d", tag, k,
                   bin_q[bb+k].a, bin_q[bb+k].d, bin_q[bb+k].c, k, bins_m[k], dc + 1 + RL + k);
        end
      end
      ref_peak(pi, pm);
      vectors++;
      if (npeak - pn !== 1 || pk_idx !== 6'(pi) || pk_mag !== 17'(pm)) begin
        errors++;
        $display("FAIL %s peak got %0d pulses idx %0d mag %0d want 1 idx %0d mag %0d", tag, npeak - pn, pk_idx, pk_mag, pi, pm);
      end
      if (nb == 64) begin
        vectors++;
        if (peak_c !== bin_q[bb+63].c) begin
          errors++; $display("FAIL %s peak_cycle got %0d want %0d", tag, peak_c, bin_q[bb+63].c);
        end
      end
      vectors++;
      if (peak_index !== 6'(pi) || peak_mag !== 17'(pm) || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s peak_hold got idx %0d mag %0d busy %b want idx %0d mag %0d busy 0", tag, peak_index, peak_mag, busy, pi, pm);
      end
    end else begin
      vectors++;
      if (nb !== 0 || busy !== 1'b0 || timeout !== 1'b1) begin
        errors++;
        $display("FAIL %s timeout_state got bins %0d busy %b timeout %b want 0 0 1", tag, nb, busy, timeout);
      end
      sc = (start_q.size() > sb) ? start_q[sb] : -1;
      vectors++;
      if (to_rise !== sc + WL) begin
        errors++; $display("FAIL %s timeout_cycle got %0d want %0d", tag, to_rise, sc + WL);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({sample_ready, fft_reset, fft_load, fft_load_address, fft_data_in, fft_start, bin_valid, bin_index,
         bin_data, peak_valid, peak_index, peak_mag, busy, timeout} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero output(s) want all 0");
    end
  endtask

  task automatic test_continuous_load();
    for (int k = 0; k < 64; k++) begin
      smp_m[k] = 16'(k * 256);
      bins_m[k] = {16'(k), 16'(-k)};
    end
    bins_m[9][31:16] = 16'h7FFF;
    run_frame(1'b0, 1'b1, "ramp");
  endtask

  task automatic test_gapped_load();
    rand_samples();
    for (int k = 0; k < 64; k++) bins_m[k] = {16'($urandom_range(0, 100)), 16'h0000};
    bins_m[5]  = {16'd250, 16'(-250)};
    bins_m[20] = {16'(-500), 16'd0};
    bins_m[40] = {16'd9000, 16'd0};
    run_frame(1'b1, 1'b1, "gap_tie");
  endtask

  task automatic test_zero_bins();
    rand_samples();
    for (int k = 0; k < 64; k++) bins_m[k] = '0;
    run_frame(1'b0, 1'b1, "zero");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      rand_samples(); rand_bins();
      if (f == 0) bins_m[3] = 32'h8000_8000;
      run_frame(1'($urandom), 1'b1, "random");
    end
  endtask

  task automatic test_back_to_back();
    rand_samples(); rand_bins();
    run_frame(1'b0, 1'b1, "b2b_a");
    rand_samples(); rand_bins();
    run_frame(1'b0, 1'b1, "b2b_b");
  endtask

  task automatic test_timeout();
    do_reset();
    rand_samples();
    run_frame(1'b0, 1'b0, "timeout");
    rand_samples(); rand_bins();
    run_frame(1'b0, 1'b1, "after_to");
    vectors++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", timeout); end
    do_reset();
    vectors++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", timeout); end
  endtask

  task automatic test_reset_mid_load();
    int idx, g;
    rand_samples();
    idx = 0; g = 0;
    while (idx < 30 && g < 100) begin
      @(negedge clk);
      sample_valid = 1'b1; sample_in = smp_m[idx];
      if (sample_ready) idx++;
      g++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({sample_ready, fft_reset, fft_load, fft_load_address, fft_data_in, fft_start, bin_valid, bin_index,
         bin_data, peak_valid, peak_index, peak_mag, busy, timeout} !== '0) begin
      errors++; $display("FAIL midload_reset got nonzero output(s) want all 0");
    end
    reset = 1'b0; sample_valid = 1'b0;
    @(negedge clk);
    rand_bins();
    run_frame(1'b0, 1'b1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_continuous_load();
    test_gapped_load();
    test_zero_bins();
    test_random_frames();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
